// File: rtl/uop_pkg.sv
// ============================================================================
//  Module   : uop_pkg
//  Purpose  : Shared types for the uop sequencer: slot layout, slot width
//             helper and sequencer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uop_pkg;

  localparam int UOP_INSTR_WIDTH = 32;
  localparam int UOP_TAG_BITS    = 2;

  // One issue slot as stored in the uop ROM; valid sits at bit 0.
  typedef struct packed {
    logic [UOP_INSTR_WIDTH-1:0] instr;
    logic [UOP_TAG_BITS-1:0]    tag;
    logic                       flag;
    logic                       valid;
  } uop_slot_t;

  // Width of one slot for an arbitrary instruction/tag size.
  function automatic int slot_width(input int instr_width, input int tag_bits);
    return instr_width + tag_bits + 2;
  endfunction

  localparam int SLOT_WIDTH = slot_width(UOP_INSTR_WIDTH, UOP_TAG_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/uop_sequencer_if.sv
// ============================================================================
//  Module   : uop_sequencer_if
//  Purpose  : Issue bus from the uop sequencer to the rename stage. One
//             bundle of ISSUE_WIDTH slots per handshake, slot 0 in the MSBs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uop_sequencer_if #(
  parameter int ISSUE_WIDTH = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int TAG_BITS    = 2
);

  logic [ISSUE_WIDTH-1:0]             out_valid;
  logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] out_instr;
  logic [ISSUE_WIDTH*TAG_BITS-1:0]    out_tag;
  logic [ISSUE_WIDTH-1:0]             out_flag;
  logic                               out_ready;

  modport master (
    output out_valid,
    output out_instr,
    output out_tag,
    output out_flag,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_tag,
    input  out_flag,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/uop_slot_decode.sv
// ============================================================================
//  Module   : uop_slot_decode
//  Purpose  : Per-bundle END detection. Finds the first END slot with a
//             prefix-OR, masks it and every later slot out of the valid
//             vector, and reports whether any END was present.
//             Vectors here are slot-indexed: bit i belongs to slot i.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uop_slot_decode
  import uop_pkg::*;
#(
  parameter  int ISSUE_WIDTH = 2,
  parameter  int INSTR_WIDTH = 32,
  parameter  int TAG_BITS    = 2,
  localparam int SW          = slot_width(INSTR_WIDTH, TAG_BITS),
  localparam int BW          = ISSUE_WIDTH * SW
) (
  input  logic [BW-1:0]          uop,
  output logic                   end_hit,
  output logic [ISSUE_WIDTH-1:0] valid_mask,
  output logic [ISSUE_WIDTH-1:0] end_onehot
);

  logic [ISSUE_WIDTH-1:0] w_valid;
  logic [ISSUE_WIDTH-1:0] w_is_end;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    localparam int HI = BW - 1 - g * SW;
    assign w_valid[g]  = uop[HI-SW+1];
    assign w_is_end[g] = uop[HI-SW+1] && (uop[HI -: INSTR_WIDTH] == '0);
  end

  // Prefix-OR over slot order: the END slot and everything after it is dropped.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    valid_mask = '0;
    end_onehot = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      end_onehot[i] = w_is_end[i] & ~acc;
      acc           = acc | w_is_end[i];
      valid_mask[i] = w_valid[i] & ~acc;
    end
    end_hit = acc;
  end

endmodule

`default_nettype wire

// File: rtl/uop_sequencer.sv
// ============================================================================
//  Module   : uop_sequencer
//  Purpose  : Multi-issue microcode sequencer. Walks the uop ROM from
//             start_addr, issuing one masked bundle per handshake until the
//             first END slot, then pulses done.
//             Optional feature macro: UOP_LOOP_EN (adds start_repeat and
//             re-runs the routine that many extra passes).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uop_sequencer
  import uop_pkg::*;
#(
  parameter  int UOP_BUF_SIZE = 128,
  parameter  int ISSUE_WIDTH  = 2,
  parameter  int INSTR_WIDTH  = 32,
  parameter  int TAG_BITS     = 2,
  parameter  int REP_BITS     = 4,
  localparam int ADDR_W       = $clog2(UOP_BUF_SIZE),
  localparam int SW           = slot_width(INSTR_WIDTH, TAG_BITS),
  localparam int BW           = ISSUE_WIDTH * SW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
`ifdef UOP_LOOP_EN
  input  logic [REP_BITS-1:0]  start_repeat,
`endif
  input  logic                 flush,
  output logic [ADDR_W-1:0]    uop_addr,
  input  logic [BW-1:0]        uop,
  uop_sequencer_if.master      out_bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ISSUE_WIDTH-1:0] C_SLOT0 = ISSUE_WIDTH'(1);

  seq_state_e                       r_state;
  logic [ADDR_W-1:0]                r_addr;
  logic [ADDR_W-1:0]                r_base;
  logic [REP_BITS-1:0]              r_rep;
  logic [ISSUE_WIDTH-1:0]           r_valid;
  logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] r_instr;
  logic [ISSUE_WIDTH*TAG_BITS-1:0]  r_tag;
  logic [ISSUE_WIDTH-1:0]           r_flag;
  logic                             r_done;

  logic                             w_end_hit;
  logic [ISSUE_WIDTH-1:0]           w_slot_valid;
  logic [ISSUE_WIDTH-1:0]           w_end_onehot;
  logic                             w_end_first;
  logic [ISSUE_WIDTH-1:0]           w_ld_valid;
  logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] w_ld_instr;
  logic [ISSUE_WIDTH*TAG_BITS-1:0]  w_ld_tag;
  logic [ISSUE_WIDTH-1:0]           w_ld_flag;
  logic                             w_load;
  logic [REP_BITS-1:0]              w_start_rep;

`ifdef UOP_LOOP_EN
  assign w_start_rep = start_repeat;
`else
  // Single pass: the repeat counter stays at zero and folds away.
  assign w_start_rep = '0;
`endif

  uop_slot_decode #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .TAG_BITS    (TAG_BITS)
  ) u_decode (
    .uop        (uop),
    .end_hit    (w_end_hit),
    .valid_mask (w_slot_valid),
    .end_onehot (w_end_onehot)
  );

  // Repack ROM slots into output order (slot 0 at the top of each field).
  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    localparam int HI = BW - 1 - g * SW;
    localparam int P  = ISSUE_WIDTH - 1 - g;
    assign w_ld_instr[P*INSTR_WIDTH +: INSTR_WIDTH] = uop[HI -: INSTR_WIDTH];
    assign w_ld_tag[P*TAG_BITS +: TAG_BITS]         = uop[HI-INSTR_WIDTH -: TAG_BITS];
    assign w_ld_flag[P]                             = uop[HI-INSTR_WIDTH-TAG_BITS];
    assign w_ld_valid[P]                            = w_slot_valid[g];
  end

  // END in slot 0 means the bundle being loaded carries nothing to issue.
  assign w_end_first = |(w_end_onehot & C_SLOT0);

  // Output register may take a new bundle when empty or being consumed.
  assign w_load = ~(|r_valid) | out_bus.out_ready;

  // Sequencer FSM with the output register, address and repeat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_base  <= '0;
      r_rep   <= '0;
      r_valid <= '0;
      r_instr <= '0;
      r_tag   <= '0;
      r_flag  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_valid <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_addr  <= start_addr;
              r_base  <= start_addr;
              r_rep   <= w_start_rep;
              r_state <= RUN;
            end
          end
          RUN: begin
            if (w_load) begin
              r_valid <= w_ld_valid;
              r_instr <= w_ld_instr;
              r_tag   <= w_ld_tag;
              r_flag  <= w_ld_flag;
              if (w_end_hit && (r_rep != '0)) begin
                r_rep  <= r_rep - 1'b1;
                r_addr <= r_base;
              end else begin
                r_addr <= r_addr + 1'b1;
                if (w_end_hit) begin
                  if (w_end_first) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                  end else begin
                    r_state <= DRAIN;
                  end
                end
              end
            end
          end
          DRAIN: begin
            if (w_load) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_valid <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign uop_addr          = r_addr;
  assign busy              = (r_state != IDLE);
  assign done              = r_done;
  assign out_bus.out_valid = r_valid;
  assign out_bus.out_instr = r_instr;
  assign out_bus.out_tag   = r_tag;
  assign out_bus.out_flag  = r_flag;

endmodule

`default_nettype wire
